// File: rtl/hwf_sv_sequencer_pkg.sv
// Shared definitions for the HWF support-vector sequencer: default sizes and
// FSM state encoding.
package hwf_sv_sequencer_pkg;

   localparam int XLEN_PIXEL_D    = 8;
   localparam int NUM_OF_PIXELS_D = 4;
   localparam int ITERATOR_D      = 8;
   localparam int NUM_SV_D        = 16;
   localparam int ACC_W_D         = 24;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_DRAIN = 3'd2;
   localparam state_t ST_ITER  = 3'd3;
   localparam state_t ST_ACC   = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

   // Cycles spent on one support vector: pixel loads, drain, iterations, accumulate.
   function automatic int cycles_per_sv(input int npix, input int iter);
      return npix + 1 + iter + 1;
   endfunction

endpackage

// File: rtl/hwf_sv_sequencer_if.sv
// Bundle of cascade-control, memory and kernel signals around the sequencer.
// The sequencer takes the master side; the stage/kernel environment the slave side.
interface hwf_sv_sequencer_if
   import hwf_sv_sequencer_pkg::*;
#(
   parameter int XLEN_PIXEL    = XLEN_PIXEL_D,
   parameter int NUM_OF_PIXELS = NUM_OF_PIXELS_D,
   parameter int ITERATOR      = ITERATOR_D,
   parameter int NUM_SV        = NUM_SV_D,
   parameter int ACC_W         = ACC_W_D
);
   localparam int SV_ADDR_W  = $clog2(NUM_SV * NUM_OF_PIXELS);
   localparam int PIX_W      = $clog2(NUM_OF_PIXELS);
   localparam int SV_W       = $clog2(NUM_SV);
   localparam int ITER_W     = $clog2(ITERATOR);

   logic                         start;
   logic                         stall_MEM;
   logic                         busy;
   logic                         done;
   logic signed [ACC_W-1:0]      score;
   logic                         decision;
   logic                         sv_rd_en;
   logic [SV_ADDR_W-1:0]         sv_addr;
   logic [PIX_W-1:0]             pix_addr;
   logic [SV_W-1:0]              sv_idx;
   logic                         k_clr;
   logic                         k_pix_vld;
   logic                         k_iter_en;
   logic [ITER_W-1:0]            k_iter_idx;
   logic [XLEN_PIXEL-1:0]        k_result;
   logic signed [XLEN_PIXEL-1:0] alpha_y;
   logic signed [ACC_W-1:0]      bias;

   modport master (
      input  start, stall_MEM, k_result, alpha_y, bias,
      output busy, done, score, decision, sv_rd_en, sv_addr, pix_addr, sv_idx,
             k_clr, k_pix_vld, k_iter_en, k_iter_idx
   );

   modport slave (
      output start, stall_MEM, k_result, alpha_y, bias,
      input  busy, done, score, decision, sv_rd_en, sv_addr, pix_addr, sv_idx,
             k_clr, k_pix_vld, k_iter_en, k_iter_idx
   );

endinterface

// File: rtl/hwf_mac.sv
// Signed multiply-accumulate: acc += alpha_y * zext(k_result), wrapping modulo 2^ACC_W.
// sum presents the value the accumulator takes on the next enabled cycle.
module hwf_mac #(
   parameter int XLEN_PIXEL = 8,
   parameter int ACC_W      = 24
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic signed [ACC_W-1:0]      load_val,
   input  logic                         en,
   input  logic [XLEN_PIXEL-1:0]        k_result,
   input  logic signed [XLEN_PIXEL-1:0] alpha_y,
   output logic signed [ACC_W-1:0]      sum
);
   localparam int PROD_W = 2 * XLEN_PIXEL + 1;

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
   endfunction

   logic signed [PROD_W-1:0] a_ext_p0;
   logic signed [PROD_W-1:0] k_ext_p0;
   logic signed [PROD_W-1:0] prod_p0;
   logic signed [ACC_W-1:0]  acc_p1;

   // Stage 0: kernel output is a magnitude, so it is zero-extended before the signed multiply
   assign a_ext_p0 = {{(PROD_W - XLEN_PIXEL){alpha_y[XLEN_PIXEL-1]}}, alpha_y};
   assign k_ext_p0 = {{(PROD_W - XLEN_PIXEL){1'b0}}, k_result};
   assign prod_p0  = a_ext_p0 * k_ext_p0;
   assign sum      = acc_p1 + sext_prod(prod_p0);

   // Stage 1: accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p1 <= '0;
      end else if (load) begin
         acc_p1 <= load_val;
      end else if (en) begin
         acc_p1 <= sum;
      end
   end

endmodule

// File: rtl/hwf_sv_sequencer.sv
// Walks every support vector of an SVM stage through the HWF kernel and
// accumulates bias + sum(alpha_y * kernel) into a signed decision score.
module hwf_sv_sequencer
   import hwf_sv_sequencer_pkg::*;
#(
   parameter int XLEN_PIXEL    = XLEN_PIXEL_D,
   parameter int NUM_OF_PIXELS = NUM_OF_PIXELS_D,
   parameter int ITERATOR      = ITERATOR_D,
   parameter int NUM_SV        = NUM_SV_D,
   parameter int ACC_W         = ACC_W_D
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hwf_sv_sequencer_if.master   bus
);
   localparam int SV_ADDR_W = $clog2(NUM_SV * NUM_OF_PIXELS);
   localparam int PIX_W     = $clog2(NUM_OF_PIXELS);
   localparam int SV_W      = $clog2(NUM_SV);
   localparam int ITER_W    = $clog2(ITERATOR);

   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(NUM_OF_PIXELS - 1);
   localparam logic [SV_W-1:0]   SV_LAST   = SV_W'(NUM_SV - 1);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERATOR - 1);

   state_t                  state_q;
   logic [SV_W-1:0]         sv_cnt_q;
   logic [PIX_W-1:0]        pix_cnt_q;
   logic [ITER_W-1:0]       iter_cnt_q;
   logic                    vld_p1;
   logic signed [ACC_W-1:0] score_q;
   logic                    decision_q;
   logic                    run_en;
   logic                    mac_load;
   logic                    mac_en;
   logic signed [ACC_W-1:0] acc_nxt;

   // A memory stall freezes every register and masks all strobes
   assign run_en   = !bus.stall_MEM;
   assign mac_load = run_en && (state_q == ST_IDLE) && bus.start;
   assign mac_en   = run_en && (state_q == ST_ACC);

   hwf_mac #(
      .XLEN_PIXEL (XLEN_PIXEL),
      .ACC_W      (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (mac_load),
      .load_val (bus.bias),
      .en       (mac_en),
      .k_result (bus.k_result),
      .alpha_y  (bus.alpha_y),
      .sum      (acc_nxt)
   );

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = run_en && (state_q == ST_DONE);
   assign bus.score      = score_q;
   assign bus.decision   = decision_q;
   assign bus.sv_rd_en   = run_en && (state_q == ST_LOAD);
   assign bus.sv_addr    = SV_ADDR_W'(sv_cnt_q * NUM_OF_PIXELS + pix_cnt_q);
   assign bus.pix_addr   = pix_cnt_q;
   assign bus.sv_idx     = sv_cnt_q;
   assign bus.k_clr      = run_en && (state_q == ST_LOAD) && (pix_cnt_q == '0);
   assign bus.k_pix_vld  = run_en && vld_p1;
   assign bus.k_iter_en  = run_en && (state_q == ST_ITER);
   assign bus.k_iter_idx = iter_cnt_q;

   // Stage 1: vld_p1 tracks the one-cycle memory read latency behind sv_rd_en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sv_cnt_q   <= '0;
         pix_cnt_q  <= '0;
         iter_cnt_q <= '0;
         vld_p1     <= 1'b0;
         score_q    <= '0;
         decision_q <= 1'b0;
      end else if (run_en) begin
         vld_p1 <= (state_q == ST_LOAD);
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q    <= ST_LOAD;
                  sv_cnt_q   <= '0;
                  pix_cnt_q  <= '0;
                  iter_cnt_q <= '0;
               end
            end
            ST_LOAD: begin
               if (pix_cnt_q == PIX_LAST) begin
                  pix_cnt_q <= '0;
                  state_q   <= ST_DRAIN;
               end else begin
                  pix_cnt_q <= pix_cnt_q + 1'b1;
               end
            end
            ST_DRAIN: state_q <= ST_ITER;
            ST_ITER: begin
               if (iter_cnt_q == ITER_LAST) begin
                  iter_cnt_q <= '0;
                  state_q    <= ST_ACC;
               end else begin
                  iter_cnt_q <= iter_cnt_q + 1'b1;
               end
            end
            ST_ACC: begin
               // The final score is captured on entry to DONE so it is stable while done is high
               if (sv_cnt_q == SV_LAST) begin
                  sv_cnt_q   <= '0;
                  state_q    <= ST_DONE;
                  score_q    <= acc_nxt;
                  decision_q <= ~acc_nxt[ACC_W-1];
               end else begin
                  sv_cnt_q <= sv_cnt_q + 1'b1;
                  state_q  <= ST_LOAD;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hwf_sv_sequencer.sv
// Bench for hwf_sv_sequencer: vector table, reset corner cases and randomized
// runs against a behavioural score/latency model.
module tb_hwf_sv_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic signed [7:0] alpha_tab [16];
   logic [7:0]        kr_tab [16];

   hwf_sv_sequencer_if bus ();

   hwf_sv_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Kernel and coefficient stub: per-SV constant kernel output and alpha_y
   assign bus.k_result = kr_tab[bus.sv_idx];
   assign bus.alpha_y  = alpha_tab[bus.sv_idx];

   typedef struct {
      logic signed [23:0] bias;
      logic signed [7:0]  alpha;
      logic [7:0]         kr;
      int                 mode;
      bit                 xstart;
      logic signed [23:0] score;
      bit                 dec;
      int                 cyc;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint out_vec();
      return longint'({bus.busy, bus.done, bus.score, bus.decision, bus.sv_rd_en,
                       bus.sv_addr, bus.pix_addr, bus.sv_idx, bus.k_clr,
                       bus.k_pix_vld, bus.k_iter_en, bus.k_iter_idx});
   endfunction

   // mode 0: no stall, 1: stall cycles 44..48 (mid-LOAD of SV 3), 2: random stalls
   task automatic run(input logic signed [23:0] b, input int mode, input bit xstart,
                      output int done_cyc, output int exp_cyc);
      int unst = 0, vld_n = 0, rd_seq = 0, it_seq = 0, seq_err = 0, idle_err = 0;
      bit pend = 0, stl = 0, seen = 0;
      done_cyc = -1;
      exp_cyc  = -1;
      @(posedge clk); #1;
      bus.bias = b; bus.stall_MEM = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.bias  = ~b;
      for (int c = 1; c <= 600 && !seen; c++) begin
         case (mode)
            1:       stl = (c >= 44 && c <= 48);
            2:       stl = ($urandom_range(0, 99) < 15);
            default: stl = 1'b0;
         endcase
         bus.stall_MEM = stl;
         if (xstart) bus.start = (c == 100) || (!stl && unst == 224);
         @(negedge clk);
         if (!stl) unst++;
         if (stl) begin
            if (bus.sv_rd_en || bus.k_pix_vld || bus.k_iter_en || bus.k_clr || bus.done)
               seq_err++;
         end else begin
            if (bus.k_pix_vld !== pend) seq_err++;
            pend = bus.sv_rd_en;
            if (bus.k_pix_vld) vld_n++;
            if (bus.sv_rd_en) begin
               if (bus.sv_addr != 6'(rd_seq) || bus.k_clr != (rd_seq % 4 == 0) ||
                   bus.pix_addr != 2'(rd_seq % 4) || bus.sv_idx != 4'(rd_seq / 4))
                  seq_err++;
               rd_seq++;
            end else if (bus.k_clr) begin
               seq_err++;
            end
            if (bus.k_iter_en) begin
               if (bus.k_iter_idx != 3'(it_seq % 8) || bus.sv_idx != 4'(it_seq / 8))
                  seq_err++;
               it_seq++;
            end
         end
         if (bus.busy !== 1'b1) seq_err++;
         if (!stl && unst == 225) exp_cyc = c;
         if (bus.done === 1'b1) begin
            done_cyc = c;
            seen = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.stall_MEM = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) idle_err++;
      end
      check("sequence_errors", seq_err, 0);
      check("k_pix_vld_count", vld_n, 64);
      check("rd_en_count", rd_seq, 64);
      check("k_iter_en_count", it_seq, 128);
      check("post_done_idle", idle_err, 0);
   endtask

   initial begin
      int dc, ec;
      longint s;
      logic signed [23:0] exp_score;

      tbl[0] = '{bias: -24'sd100, alpha: 8'sd3,  kr: 8'd10, mode: 0, xstart: 0, score: 24'sd380,  dec: 1, cyc: 225};
      tbl[1] = '{bias: -24'sd100, alpha: -8'sd3, kr: 8'd10, mode: 0, xstart: 0, score: -24'sd580, dec: 0, cyc: 225};
      tbl[2] = '{bias: -24'sd100, alpha: 8'sd3,  kr: 8'd10, mode: 1, xstart: 0, score: 24'sd380,  dec: 1, cyc: 230};
      tbl[3] = '{bias: 24'sd0, alpha: -8'sd128, kr: 8'd255, mode: 0, xstart: 1, score: -24'sd522240, dec: 0, cyc: 225};
      tbl[4] = '{bias: 24'sh7FFFFF, alpha: 8'sd127, kr: 8'd255, mode: 0, xstart: 0, score: -24'sd7870449, dec: 0, cyc: 225};
      tbl[5] = '{bias: 24'sd0,  alpha: 8'sd0, kr: 8'd77, mode: 0, xstart: 0, score: 24'sd0,  dec: 1, cyc: 225};
      tbl[6] = '{bias: -24'sd1, alpha: 8'sd0, kr: 8'd77, mode: 0, xstart: 1, score: -24'sd1, dec: 0, cyc: 225};

      bus.start = 1'b0; bus.stall_MEM = 1'b0; bus.bias = '0;
      for (int i = 0; i < 16; i++) begin alpha_tab[i] = 8'sd0; kr_tab[i] = 8'd0; end
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", out_vec(), 0);
      @(negedge clk) rst_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < 16; i++) begin alpha_tab[i] = tbl[v].alpha; kr_tab[i] = tbl[v].kr; end
         run(tbl[v].bias, tbl[v].mode, tbl[v].xstart, dc, ec);
         check($sformatf("vec%0d_done_cycle", v), dc, tbl[v].cyc);
         check($sformatf("vec%0d_score", v), bus.score, tbl[v].score);
         check($sformatf("vec%0d_decision", v), bus.decision, tbl[v].dec);
      end

      // Reset during ITER of SV 7 (cycle 107, iteration 3)
      for (int i = 0; i < 16; i++) begin alpha_tab[i] = 8'sd3; kr_tab[i] = 8'd10; end
      @(posedge clk); #1;
      bus.bias = -24'sd100; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (106) @(posedge clk);
      #2;
      check("pre_reset_iter_en", bus.k_iter_en, 1);
      check("pre_reset_iter_idx", bus.k_iter_idx, 3);
      check("pre_reset_sv_idx", bus.sv_idx, 7);
      rst_n = 1'b0;
      #1;
      check("midrun_reset_outputs", out_vec(), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("held_reset_outputs", out_vec(), 0);
      rst_n = 1'b1;
      run(-24'sd100, 0, 1'b0, dc, ec);
      check("after_reset_done_cycle", dc, 225);
      check("after_reset_score", bus.score, 380);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) begin
            alpha_tab[i] = 8'($urandom);
            kr_tab[i]    = 8'($urandom);
         end
         exp_score = 24'($urandom);
         s = longint'(exp_score);
         for (int i = 0; i < 16; i++) s += longint'(alpha_tab[i]) * longint'(kr_tab[i]);
         run(exp_score, 2, r[0], dc, ec);
         exp_score = s[23:0];
         check($sformatf("rand%0d_done_cycle", r), dc, ec);
         check($sformatf("rand%0d_score", r), bus.score, exp_score);
         check($sformatf("rand%0d_decision", r), bus.decision, (exp_score >= 0) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hwf_sv_sequencer.md
# hwf_sv_sequencer

Controller that sequences the HWF kernel datapath over every support vector of a trained SVM stage for one test vector. It streams pixel pairs from the support-vector and test-vector memories into the kernel, runs the kernel's shift-add iterations, and accumulates the signed weighted sum of kernel outputs into a decision score. It sits between the stage-level cascade control (start/done) and one HWF kernel instance plus its memories.

## Interface
- XLEN_PIXEL, 8, pixel / kernel-output width
- NUM_OF_PIXELS, 4, pixels per vector
- ITERATOR, 8, shift-add iterations per kernel evaluation
- NUM_SV, 16, support vectors in this stage
- ACC_W, 24, score accumulator width

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin classification (ignored unless IDLE)
- stall_MEM  in  1  memory stall; freezes sequencer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when score is final
- score  out  ACC_W signed  final decision value
- decision  out  1  1 when score >= 0
- sv_rd_en  out  1  read strobe to SV and test memories
- sv_addr  out  clog2(NUM_SV*NUM_OF_PIXELS)  SV memory address = sv_idx*NUM_OF_PIXELS + pix_idx
- pix_addr  out  clog2(NUM_OF_PIXELS)  test memory address
- sv_idx  out  clog2(NUM_SV)  current SV; addresses coefficient ROM
- k_clr  out  1  clear kernel norm accumulator
- k_pix_vld  out  1  pixel pair valid at kernel inputs
- k_iter_en  out  1  perform one kernel iteration
- k_iter_idx  out  clog2(ITERATOR)  iteration index (shift amount)
- k_result  in  XLEN_PIXEL unsigned  kernel output, valid in ACC
- alpha_y  in  XLEN_PIXEL signed  coefficient of sv_idx, valid in ACC
- bias  in  ACC_W signed  stage bias, sampled on accepted start

## Operation
- States: IDLE, LOAD, DRAIN, ITER, ACC, DONE.
- IDLE: start -> LOAD; acc <= bias; sv_cnt, pix_cnt, iter_cnt <= 0.
- LOAD: sv_rd_en=1, address from sv_cnt/pix_cnt; k_clr=1 when pix_cnt==0; pix_cnt increments; after pix_cnt==NUM_OF_PIXELS-1 -> DRAIN.
- Memories have 1-cycle read latency: k_pix_vld = sv_rd_en registered (one cycle later).
- DRAIN: one cycle carrying last k_pix_vld -> ITER.
- ITER: k_iter_en=1, k_iter_idx=iter_cnt; after iter_cnt==ITERATOR-1 -> ACC.
- ACC: acc <= acc + sext(alpha_y * zext(k_result)) (2*XLEN_PIXEL+1-bit signed product); if sv_cnt==NUM_SV-1 -> DONE else sv_cnt++, counters clear, -> LOAD.
- DONE: score <= acc; decision <= ~acc[ACC_W-1]; done=1; -> IDLE.
- Accumulation wraps modulo 2^ACC_W; no saturation.
- stall_MEM high: state, counters, acc and the pending-valid register hold; sv_rd_en, k_pix_vld, k_iter_en, k_clr, done forced 0; pending valid reissued on first unstalled cycle.
- start outside IDLE ignored. score/decision hold until next DONE.

## Timing
- Reset values: all outputs 0, state IDLE, acc 0.
- Reset mid-operation: immediate return to IDLE, no done, score/decision cleared.
- Per SV: NUM_OF_PIXELS + 1 + ITERATOR + 1 cycles (14 default).
- done asserts NUM_SV*(NUM_OF_PIXELS+ITERATOR+2)+1 cycles after the start-accept edge (225 default), plus stalled cycles.
- Exactly NUM_SV*NUM_OF_PIXELS k_pix_vld and NUM_SV*ITERATOR k_iter_en pulses per run.
- start in the same cycle as done: ignored (state is DONE).

## Structure
- Shared package: state encoding, localparams for counter widths and per-SV cycle count.
- One sub-module natural: hwf_mac (signed multiply-accumulate with enable/load).

## Test plan
- Stub kernel k_result=10, alpha_y=+3 all SVs, bias=-100 -> score=380, decision=1, done at cycle 225.
- alpha_y=-3, same else -> score=-580, decision=0.
- Address check: sv_addr 0..63 in order, k_clr at sv_addr 0,4,8..., k_iter_idx 0..7 per SV, k_pix_vld one cycle after each sv_rd_en.
- 5-cycle stall_MEM mid-LOAD of SV 3 -> done at cycle 230, score unchanged, still 64 k_pix_vld.
- rst_n low during ITER of SV 7 -> all outputs 0 immediately; new start gives 380 at 225 cycles.
- start pulsed while busy and in DONE -> ignored, single done per run.
